decodificador_7seg_bcd: RTL



---
 rtl/decodificador_7seg_bcd.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/decodificador_7seg_bcd.sv
// 7-segment bus reader: debounces each multiplexed digit and
// decodes its active-low segment pattern back to BCD.
module decodificador_7seg_bcd #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg,
    input  logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   dp_out,
    output logic [NDIG-1:0]   dig_valid,
    output logic [NDIG-1:0]   dig_err,
    output logic              an_err,
    output logic              frame_done
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [7:0]      s_seg;
    logic [NDIG-1:0] s_an;
    logic [NDIG-1:0] seen, seen_n;
    logic [IW-1:0]   idx;
    logic [3:0]      code;
    logic            one_hot;
    logic            multi;
    logic            same;
    logic            commit;
    int              n_low;

    function automatic logic [3:0] decode(input logic [6:0] p);
        logic [3:0] r;
        case (p)
            7'b0000001: r = 4'h0;
            7'b1001111: r = 4'h1;
            7'b0010010: r = 4'h2;
            7'b0000110: r = 4'h3;
            7'b1001100: r = 4'h4;
            7'b0100100: r = 4'h5;
            7'b0100000: r = 4'h6;
            7'b0001111: r = 4'h7;
            7'b0000000: r = 4'h8;
            7'b0001100: r = 4'h9;
            7'b1111111: r = 4'hF;
            default:    r = 4'hE;
        endcase
        return r;
    endfunction

    // Classify the sample being captured this edge; the input register
    // holds the previous sample it is compared against, so the commit
    // lands on the same edge that captures the last stable sample.
    always_comb begin
        n_low   = $countones(~an);
        one_hot = (n_low == 1);
        multi   = (n_low > 1);
        same    = ({an, seg} == {s_an, s_seg});
        code    = decode(seg[7:1]);
        idx     = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an[i]) idx = IW'(i);
        end
    end

    // Settle tracker: next state, saturating count and commit strobe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    cnt_n   = CW'(1);
                    state_n = TRACK;
                end else begin
                    cnt_n = '0;
                end
            end
            TRACK: begin
                if (!one_hot) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (same) begin
                    if (cnt < STABLE_C) cnt_n = cnt + CW'(1);
                    if (cnt_n == STABLE_C) begin
                        commit  = 1'b1;
                        state_n = HELD;
                    end
                end else begin
                    cnt_n = CW'(1);
                end
            end
            HELD: begin
                if (!one_hot) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (!same) begin
                    cnt_n   = CW'(1);
                    state_n = TRACK;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Frame mask: clears the cycle after it fills, keeping any commit
    // that lands on that same edge.
    always_comb begin
        seen_n = (&seen) ? '0 : seen;
        if (commit) seen_n[idx] = 1'b1;
    end

    // Input samples, tracker state and frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg      <= '1;
            s_an       <= '1;
            state      <= IDLE;
            cnt        <= '0;
            seen       <= '0;
            an_err     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s_seg      <= seg;
            s_an       <= an;
            state      <= state_n;
            cnt        <= cnt_n;
            seen       <= seen_n;
            an_err     <= multi;
            frame_done <= &seen;
        end
    end

    // Committed per-digit results, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd       <= '0;
            dp_out    <= '0;
            dig_valid <= '0;
            dig_err   <= '0;
        end else if (commit) begin
            bcd[4*idx +: 4] <= code;
            dp_out[idx]     <= ~seg[0];
            dig_valid[idx]  <= 1'b1;
            dig_err[idx]    <= (code == 4'hE);
        end
    end

endmodule
